// File: rtl/spike_rate_decoder.sv
// Spike-train receiver: counts spikes and measures the latest inter-spike interval over a
// programmable window, then holds {rate, isi, overflow} on a valid/ready output.
module spike_rate_decoder #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic [ISI_W-1:0] isi_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             missed
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_ONE  = {{(ISI_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W:0]   SAMP_ONE = {{WIN_W{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIN_W:0]     len_q, len_d;
  logic [WIN_W:0]     samp_q, samp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ISI_W-1:0]   gap_q, gap_d;
  logic               seen_q, seen_d;
  logic [ISI_W-1:0]   isi_q, isi_d;
  logic [CNT_W-1:0]   rate_q, rate_d;
  logic [ISI_W-1:0]   isi_out_q, isi_out_d;
  logic               ovf_out_q, ovf_out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               missed_q, missed_d;
  logic               start_s;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    samp_d    = samp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    gap_d     = gap_q;
    seen_d    = seen_q;
    isi_d     = isi_q;
    rate_d    = rate_q;
    isi_out_d = isi_out_q;
    ovf_out_d = ovf_out_q;
    start_s   = 1'b0;
    // The handshake edge is still HOLD, so a spike there is dropped and flagged.
    missed_d  = missed_q | (spike_in & (state_q != S_COUNT));

    case (state_q)
      S_IDLE: begin
        if (en) start_s = 1'b1;
        else    state_d = S_IDLE;
      end
      S_COUNT: begin
        samp_d = samp_q + SAMP_ONE;
        if (spike_in) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_ONE;
          if (seen_q) isi_d = (gap_q == ISI_MAX) ? ISI_MAX : gap_q + ISI_ONE;
          else        isi_d = isi_q;
          seen_d = 1'b1;
          gap_d  = {ISI_W{1'b0}};
        end else if (seen_q && (gap_q != ISI_MAX)) begin
          gap_d = gap_q + ISI_ONE;
        end else begin
          gap_d = gap_q;
        end
        if (samp_d == len_q) begin
          state_d   = S_HOLD;
          rate_d    = cnt_d;
          isi_out_d = isi_d;
          ovf_out_d = ovf_d;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (en) start_s = 1'b1;
          else    state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A zero length encodes the full 2**WIN_W window.
    if (start_s) begin
      state_d = S_COUNT;
      len_d   = (window_len == {WIN_W{1'b0}}) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len};
      samp_d  = {(WIN_W+1){1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      ovf_d   = 1'b0;
      gap_d   = {ISI_W{1'b0}};
      seen_d  = 1'b0;
      isi_d   = {ISI_W{1'b0}};
    end else begin
      len_d = len_q;
    end

    valid_d = (state_d == S_HOLD);
    busy_d  = (state_d == S_COUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= {(WIN_W+1){1'b0}};
      samp_q    <= {(WIN_W+1){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      ovf_q     <= 1'b0;
      gap_q     <= {ISI_W{1'b0}};
      seen_q    <= 1'b0;
      isi_q     <= {ISI_W{1'b0}};
      rate_q    <= {CNT_W{1'b0}};
      isi_out_q <= {ISI_W{1'b0}};
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      samp_q    <= samp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      gap_q     <= gap_d;
      seen_q    <= seen_d;
      isi_q     <= isi_d;
      rate_q    <= rate_d;
      isi_out_q <= isi_out_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      missed_q  <= missed_d;
    end
  end

  assign rate_out  = rate_q;
  assign isi_out   = isi_out_q;
  assign overflow  = ovf_out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign missed    = missed_q;

endmodule
